// File: rtl/firstcode_pkg.sv
// Shared constants for the firstcode logic cell.
// Truth-table entry index is {a,b}: 0=(0,0) 1=(0,1) 2=(1,0) 3=(1,1).
package firstcode_pkg;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [1:0] tt_idx(
    input logic a,
    input logic b
  );
    return {a, b};
  endfunction

endpackage

// File: rtl/firstcode_if.sv
// Operand, truth-table and result bundle of the firstcode cell.
// Master drives operands and table; slave returns the result.
interface firstcode_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       TT;
  logic             TT_LOAD;
  logic [WIDTH-1:0] C;
  logic             C_CHANGED;
  logic [CNT_W-1:0] CHG_CNT;

  modport master (
    output A, B, TT, TT_LOAD,
    input  C, C_CHANGED, CHG_CNT
  );

  modport slave (
    input  A, B, TT, TT_LOAD,
    output C, C_CHANGED, CHG_CNT
  );

endinterface

// File: rtl/firstcode_tt_lut2.sv
// One-bit combinational truth-table lookup.
// Output is tt_i selected by the {a,b} index.
module tt_lut2
  import firstcode_pkg::*;
(
  input  logic [3:0] tt_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_o
);

  assign y_o = tt_i[tt_idx(a_i, b_i)];

endmodule

// File: rtl/firstcode.sv
// Registered programmable two-input logic cell with
// change flag and saturating change counter.
module firstcode
  import firstcode_pkg::*;
#(
  parameter int         WIDTH      = 1,
  parameter logic [3:0] DEFAULT_TT = TT_AND,
  parameter int         CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  firstcode_if.slave bus
);

  logic [3:0]       fn_q, fn_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lut
    tt_lut2 u_lut (
      .tt_i (fn_q),
      .a_i  (bus.A[g]),
      .b_i  (bus.B[g]),
      .y_o  (c_d[g])
    );
  end

  // The result at a load edge still uses the old table.
  always_comb begin
    fn_d  = fn_q;
    chg_d = (c_d != c_q);
    cnt_d = cnt_q;
    if (bus.TT_LOAD) fn_d = bus.TT;
    if (chg_d && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fn_q  <= DEFAULT_TT;
      c_q   <= '0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      fn_q  <= fn_d;
      c_q   <= c_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.C         = c_q;
  assign bus.C_CHANGED = chg_q;
  assign bus.CHG_CNT   = cnt_q;

endmodule

// File: tb/tb_firstcode.sv
// Scoreboard bench for firstcode: WIDTH=4, CNT_W=4,
// directed plan steps followed by random traffic.
module tb_firstcode;

  localparam int W  = 4;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0]  c;
    logic          chg;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int m_fn  = 8;
  int m_c   = 0;
  int m_cnt = 0;

  firstcode_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  firstcode #(
    .WIDTH      (W),
    .DEFAULT_TT (4'b1000),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: C bit i = bit {A[i],B[i]} of the table.
  task automatic step(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [3:0]   tt,
    input logic         ld,
    input logic         r,
    input string        tag
  );
    exp_t e;
    int   nc;
    int   ch;
    @(negedge clk);
    bus.A       = a;
    bus.B       = b;
    bus.TT      = tt;
    bus.TT_LOAD = ld;
    rst         = r;
    if (r) begin
      m_fn  = 8;
      m_c   = 0;
      m_cnt = 0;
      ch    = 0;
    end else begin
      nc = 0;
      for (int i = 0; i < W; i++) begin
        int idx;
        idx = 2 * int'(a[i]) + int'(b[i]);
        nc  = nc + (((m_fn >> idx) & 1) << i);
      end
      ch = (nc != m_c) ? 1 : 0;
      if (ch == 1 && m_cnt < (1 << CW) - 1) m_cnt++;
      m_c = nc;
      if (ld) m_fn = int'(tt);
    end
    e.c   = W'(m_c);
    e.chg = (ch == 1);
    e.cnt = CW'(m_cnt);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.C !== e.c) begin
        bad++;
        $display("FAIL %s C got=%b want=%b",
                 e.tag, bus.C, e.c);
      end
      total++;
      if (bus.C_CHANGED !== e.chg) begin
        bad++;
        $display("FAIL %s C_CHANGED got=%b want=%b",
                 e.tag, bus.C_CHANGED, e.chg);
      end
      total++;
      if (bus.CHG_CNT !== e.cnt) begin
        bad++;
        $display("FAIL %s CHG_CNT got=%0d want=%0d",
                 e.tag, bus.CHG_CNT, e.cnt);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    int           wait_cnt;
    bus.A       = '0;
    bus.B       = '0;
    bus.TT      = '0;
    bus.TT_LOAD = 1'b0;

    step(4'h0, 4'h0, 4'h0, 0, 1, "rst0");
    step(4'h0, 4'h0, 4'h0, 0, 1, "rst1");

    step(4'h0, 4'h1, 4'h0, 0, 0, "and01");
    step(4'h0, 4'h0, 4'h0, 0, 0, "and00");
    step(4'h1, 4'h0, 4'h0, 0, 0, "and10");
    step(4'h1, 4'h1, 4'h0, 0, 0, "and11");

    step(4'hf, 4'hf, 4'h0, 0, 1, "rst_ab1");

    step(4'h1, 4'h0, 4'b0110, 1, 0, "ld_old");
    step(4'h1, 4'h0, 4'h0, 0, 0, "ld_xor");
    step(4'h1, 4'h1, 4'h0, 0, 0, "xor11");

    step(4'h0, 4'h0, 4'h0, 0, 1, "rst_b");
    step(4'h0, 4'h1, 4'b1110, 0, 0, "no_ld");

    step(4'h0, 4'h0, 4'b0110, 1, 0, "ld_x");
    a = 4'h0;
    for (int i = 0; i < 20; i++) begin
      a = ~a;
      step(a, 4'h0, 4'h0, 0, 0, "toggle");
    end

    step(4'h0, 4'h0, 4'h0, 0, 1, "rst_c");
    step(4'h0, 4'h0, 4'b1110, 1, 0, "ld_or");
    step(4'b1100, 4'b1010, 4'h0, 0, 0, "or_v");
    step(4'b1100, 4'b1010, 4'h0, 0, 1, "mid_rst");
    step(4'b1100, 4'b1010, 4'h0, 0, 0, "post_and");

    for (int i = 0; i < 300; i++) begin
      step(W'($urandom), W'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) == 0), "rand");
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
